// File: rtl/jt51_slot_capture.sv
// jt51_slot_capture: aligns to the 32-slot operator sequence, captures one
// frame of a pipeline tap and streams it out in ch/op order over valid/ready.
module jt51_slot_capture #(
  parameter int WIDTH = 10,
  parameter int STG   = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cen,
  input  logic [4:0]       cnt,
  input  logic [WIDTH-1:0] mixed,
  input  logic             arm,
  input  logic             abort,
  output logic             busy,
  output logic             done,
  output logic             rd_valid,
  input  logic             rd_ready,
  output logic [WIDTH-1:0] rd_data,
  output logic [2:0]       rd_ch,
  output logic [1:0]       rd_op,
  output logic             rd_last
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ALIGN = 2'd1;
  localparam logic [1:0] S_CAPT  = 2'd2;
  localparam logic [1:0] S_READ  = 2'd3;

  // stage offset folded into one 5-bit constant so adj wraps for any STG
  localparam int         OFS_I = (64 + 33 - (STG % 32)) % 32;
  localparam logic [4:0] OFS   = 5'(OFS_I);

  logic [1:0]       state_q, state_d;
  logic [4:0]       wcnt_q, wcnt_d;
  logic [4:0]       raddr_q, raddr_d;
  logic             valid_q, valid_d;
  logic             last_q, last_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] data_q, data_d;

  logic [WIDTH-1:0] mem [32];

  logic [4:0]       adj;
  logic [4:0]       waddr;
  logic [4:0]       raddr_nx;
  logic             wr_en;

  assign adj      = cnt + OFS;
  // adj[4:3] -> op is a bit swap: 0->0, 1->2, 2->1, 3->3
  assign waddr    = {adj[3], adj[4], adj[2:0]};
  assign raddr_nx = raddr_q + 5'd1;

  always_comb begin
    state_d = state_q;
    wcnt_d  = wcnt_q;
    raddr_d = raddr_q;
    valid_d = valid_q;
    last_d  = last_q;
    done_d  = 1'b0;
    data_d  = data_q;
    wr_en   = 1'b0;
    if (abort) begin
      state_d = S_IDLE;
      wcnt_d  = '0;
      raddr_d = '0;
      valid_d = 1'b0;
      last_d  = 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (arm) begin
            state_d = S_ALIGN;
            wcnt_d  = '0;
          end
        end
        S_ALIGN: begin
          if (cen && adj == 5'd0) begin
            wr_en   = 1'b1;
            wcnt_d  = 5'd1;
            state_d = S_CAPT;
          end
        end
        S_CAPT: begin
          if (cen) begin
            wr_en  = 1'b1;
            wcnt_d = wcnt_q + 5'd1;
            if (wcnt_q == 5'd31) begin
              state_d = S_READ;
              raddr_d = '0;
            end
          end
        end
        S_READ: begin
          if (!valid_q) begin
            valid_d = 1'b1;
            data_d  = mem[raddr_q];
            last_d  = &raddr_q;
          end else if (rd_ready) begin
            if (&raddr_q) begin
              state_d = S_IDLE;
              raddr_d = '0;
              valid_d = 1'b0;
              last_d  = 1'b0;
              done_d  = 1'b1;
            end else begin
              raddr_d = raddr_nx;
              data_d  = mem[raddr_nx];
              last_d  = &raddr_nx;
            end
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      wcnt_q  <= '0;
      raddr_q <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      done_q  <= 1'b0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
      raddr_q <= raddr_d;
      valid_q <= valid_d;
      last_q  <= last_d;
      done_q  <= done_d;
      data_q  <= data_d;
    end
  end

  // frame storage survives abort and reset
  always_ff @(posedge clk) begin
    if (wr_en) mem[waddr] <= mixed;
  end

  assign busy     = (state_q != S_IDLE);
  assign done     = done_q;
  assign rd_valid = valid_q;
  assign rd_data  = data_q;
  assign rd_ch    = raddr_q[2:0];
  assign rd_op    = raddr_q[4:3];
  assign rd_last  = last_q;

endmodule

// File: doc/jt51_slot_capture.md
# jt51_slot_capture

Capture-and-readout controller for a time-multiplexed JT51 pipeline signal. On request it aligns to the 32-slot operator sequence at a configurable pipeline stage and stores exactly one full frame, 8 channels × 4 operators, into an internal buffer. It then streams the frame out in channel/operator order over a valid/ready port. It sits beside the operator pipeline in simulation and debug builds and provides the block that sequences and owns the per-slot capture resource.

## Interface
Parameters:
- WIDTH, 10: width of the captured signal.
- STG, 0: pipeline stage of the tapped signal. A signal named xx_VIII uses STG=8.

Ports:
- clk  in  1: system clock.
- rst_n  in  1: reset, asynchronous, active-low.
- cen  in  1: clock enable; one slot advances per cycle with cen=1.
- cnt  in  5: global slot counter, valid when cen=1.
- mixed  in  WIDTH: time-multiplexed signal at stage STG.
- arm  in  1: capture request; one-cycle pulse or level.
- abort  in  1: cancels any operation.
- busy  out  1: high in every state except IDLE.
- done  out  1: one-cycle pulse after the last readout beat is accepted.
- rd_valid  out  1: readout data valid.
- rd_ready  in  1: consumer accepts the beat.
- rd_data  out  WIDTH: captured value.
- rd_ch  out  3: channel 0–7 of rd_data.
- rd_op  out  2: operator, 0=slot1, 1=slot2, 2=slot3, 3=slot4.
- rd_last  out  1: high on the final beat (ch 7, op 3).

## Operation
- Slot decode:
  - adj = (cnt + 33 − STG) mod 32, computed in 5 bits.
  - ch = adj[2:0].
  - adj[4:3] maps to op as 0→0 (slot1), 1→2 (slot3), 2→1 (slot2), 3→3 (slot4).
- Buffer: 32 × WIDTH. Address = op*8 + ch.
- FSM states: IDLE, ALIGN, CAPT, READ.
  - IDLE: arm=1 → ALIGN. arm is ignored in every other state.
  - ALIGN: wait for a cycle with cen=1 and adj=0. On that cycle, write mixed to address 0, set wcnt=1, go to CAPT.
  - CAPT: on each cen=1 cycle, write mixed at the decoded address and increment wcnt. When the write with wcnt=31 happens, go to READ. Cycles with cen=0 write nothing.
  - READ: raddr runs 0..31. Each accepted beat (rd_valid & rd_ready) increments raddr. Acceptance at raddr=31 → IDLE and pulse done.
- abort=1 in any state → IDLE on the next edge.
  - rd_valid, rd_last and done are forced to 0.
  - Buffer contents are kept.
  - abort has priority over arm and over the handshake.
- The buffer is fully overwritten by every capture. No partial frame is ever read out.

## Timing
- Reset values: busy=0, done=0, rd_valid=0, rd_last=0, rd_data=0, rd_ch=0, rd_op=0. State=IDLE, wcnt=0, raddr=0.
- busy rises on the edge after arm is sampled in IDLE. It falls on the same edge that returns the FSM to IDLE.
- ALIGN latency: 0–31 cen cycles. Capture takes exactly 32 cen cycles, including the aligning one.
- Readout uses a registered read:
  - rd_valid first rises 1 clk after entering READ.
  - rd_data, rd_ch, rd_op and rd_last stay stable while rd_valid=1 and rd_ready=0.
  - With rd_ready held at 1, one beat is transferred per clk. The 32 beats complete 33 clks after entering READ.
  - The readout handshake ignores cen.
- done is high for exactly 1 clk, on the edge after the last accepted beat, coincident with busy=0.
- If cen=0 on the aligning cycle, alignment waits for the next adj=0 cen cycle.
- An asynchronous rst_n assertion mid-capture or mid-readout immediately applies the reset values above.
- The mod-32 wrap of adj must hold for every cnt when STG ≥ 2.

## Test plan
- Alignment, STG=0, cen always 1, arm while cnt=10: the first write occurs at cnt=31. Capture ends 32 clks later, and busy stays high through readout.
- Mapping, STG=8, mixed = cnt driven each cycle, rd_ready=1: the beat with ch=3, op=1 (slot2) returns value (19+8−1) mod 32 = 26. All 32 beats arrive in order ch0..7 within op0..3, and rd_last is set only on ch7/op3.
- Backpressure: rd_ready toggles 1,0,0,1… during readout. No beat is lost or duplicated, outputs stay stable while stalled, and done pulses once after 32 acceptances.
- cen gating, cen=1 every 3rd clk: captured values equal the mixed value present on cen cycles only. The capture spans 96 clks.
- Abort: abort in CAPT at wcnt=15 → next edge busy=0, done=0. A re-arm then runs a complete new capture.
- Reset mid-READ: rst_n low during raddr=5 → all outputs 0 at once. After release, the FSM is in IDLE and arm starts a fresh capture.
